pi_mul_sequencer: RTL

- Control stage that feeds and consumes the shared 32x32 signed multiplier in the PI module.
- Accepts one signed error sample, then time-multiplexes the multiplier for Kp*err and Ki*err.
- Scales both products, updates a clamped integrator and emits a saturated 32-bit control output.
- Sits between the error source and the actuator/output register.

---
 rtl/pi_mul_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pi_mul_sequencer.sv
// pi_mul_sequencer
//   Control stage of the PI controller. It accepts one signed error sample,
//   time-multiplexes an external 32x32 signed multiplier for Kp*err and
//   Ki*err, scales both products by FRAC, updates a clamped integrator and
//   emits a saturated 32-bit control output.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   err_in/err_valid: error sample handshake in; err_ready high only in IDLE
//   kp, ki          : signed Q(32-FRAC).FRAC gains, sampled on accept
//   clr_int         : synchronous integrator clear (any state)
//   mul_a, mul_b    : registered multiplier operands
//   mul_result      : signed 64-bit product, stable MUL_LAT cycles after operands
//   u_out, u_valid  : registered control output and one-cycle update pulse
//   sat_flag        : last update was clamped
//   busy            : not in IDLE
module pi_mul_sequencer #(
    parameter int                 MUL_LAT = 2,
    parameter int                 FRAC    = 16,
    parameter logic signed [31:0] OUT_MAX = 32'sh7FFF_FFFF,
    parameter logic signed [31:0] OUT_MIN = -32'sh7FFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] err_in,
    input  logic               err_valid,
    output logic               err_ready,
    input  logic signed [31:0] kp,
    input  logic signed [31:0] ki,
    input  logic               clr_int,
    output logic signed [31:0] mul_a,
    output logic signed [31:0] mul_b,
    input  logic signed [63:0] mul_result,
    output logic signed [31:0] u_out,
    output logic               u_valid,
    output logic               sat_flag,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P_MUL = 3'd1,
        I_MUL = 3'd2,
        SUM   = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int CW = $clog2(MUL_LAT + 2);
    localparam logic signed [33:0] MAX34 = 34'(OUT_MAX);
    localparam logic signed [33:0] MIN34 = 34'(OUT_MIN);

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               mul_last;
    logic signed [31:0] ki_r;
    logic signed [31:0] p_term;
    logic signed [31:0] i_term;
    logic signed [31:0] integ;

    logic signed [63:0] prod_sh;
    logic signed [31:0] prod_sat;
    logic signed [33:0] integ_sum;
    logic signed [31:0] integ_new;
    logic               integ_clamped;
    logic signed [33:0] out_sum;
    logic signed [31:0] out_new;
    logic               out_clamped;

    // The multiplier only covers +/-(2^31-1), so the most negative value is
    // nudged by one LSB.
    function automatic logic signed [31:0] fix_min(input logic signed [31:0] v);
        return (v == 32'sh8000_0000) ? 32'sh8000_0001 : v;
    endfunction

    function automatic logic signed [31:0] clamp34(input logic signed [33:0] v);
        if (v > MAX34)
            return OUT_MAX;
        else if (v < MIN34)
            return OUT_MIN;
        else
            return v[31:0];
    endfunction

    assign mul_last = (cnt == CW'(MUL_LAT));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (err_valid) state_nxt = P_MUL;
            P_MUL:   if (mul_last)  state_nxt = I_MUL;
            I_MUL:   if (mul_last)  state_nxt = SUM;
            SUM:     state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        err_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        prod_sh = mul_result >>> FRAC;
        if (prod_sh > 64'sh0000_0000_7FFF_FFFF)
            prod_sat = 32'sh7FFF_FFFF;
        else if (prod_sh < -64'sh0000_0000_8000_0000)
            prod_sat = 32'sh8000_0000;
        else
            prod_sat = prod_sh[31:0];

        integ_sum = 34'(integ) + 34'(i_term);
        if (clr_int) begin
            integ_new     = '0;
            integ_clamped = 1'b0;
        end else begin
            integ_new     = clamp34(integ_sum);
            integ_clamped = (integ_sum > MAX34) || (integ_sum < MIN34);
        end

        out_sum     = 34'(p_term) + 34'(integ_new);
        out_new     = clamp34(out_sum);
        out_clamped = (out_sum > MAX34) || (out_sum < MIN34);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ki_r     <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            p_term   <= '0;
            i_term   <= '0;
            integ    <= '0;
            u_out    <= '0;
            u_valid  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            u_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (err_valid) begin
                        mul_a <= fix_min(err_in);
                        mul_b <= fix_min(kp);
                        ki_r  <= fix_min(ki);
                    end
                end
                P_MUL: begin
                    cnt <= cnt + CW'(1);
                    if (mul_last) begin
                        p_term <= prod_sat;
                        mul_b  <= ki_r;
                        cnt    <= '0;
                    end
                end
                I_MUL: begin
                    cnt <= cnt + CW'(1);
                    if (mul_last) begin
                        i_term <= prod_sat;
                        mul_a  <= '0;
                        mul_b  <= '0;
                        cnt    <= '0;
                    end
                end
                SUM: begin
                    // Output is registered here so it is visible during OUT.
                    // The flag also covers integrator clamping, which is what
                    // holds u_out at the rail under anti-windup.
                    integ    <= integ_new;
                    u_out    <= out_new;
                    u_valid  <= 1'b1;
                    sat_flag <= out_clamped || integ_clamped;
                end
                OUT: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
            if (clr_int)
                integ <= '0;
        end
    end

endmodule
